modular_inv: RTL
================

Name: modular_inv

Overview:
- Sequential modular inverter over the same scalar field as the pipelined modular multiplier.
- Computes inv_out = a_in^-1 mod M using binary extended Euclid, one step per clock.
- Operands and results are standard-domain residues, not Montgomery form, so the result feeds modular_mul directly.
- Used by the polynomial/proof datapath for field division and batch-inversion finalisation.

Parameters:
- data_width, 256, operand/result width.
- M, 256'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000001, odd prime modulus.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  request; sampled only when busy=0.
- a_in  input  data_width  operand, sampled on the accepting edge.
- busy  output  1  high while an inversion is in progress.
- done  output  1  one-cycle pulse; inv_out and err are valid in that cycle.
- err  output  1  high with done when a_in==0 or a_in>=M.
- inv_out  output  data_width  result; held until the next done.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: busy=0, done=0, err=0, inv_out=0, state=IDLE. All internal registers are cleared.
- Reset mid-run aborts the run: no done pulse, returns to IDLE next cycle.

FSM states: IDLE, RUN.
- IDLE, start=1, a_in==0 or a_in>=M:
  - stay IDLE; next cycle done=1, err=1, inv_out=0.
  - latency 1.
- IDLE, start=1, valid a_in:
  - load u=a_in, v=M, x1=1, x2=0.
  - go to RUN; busy=1 from next cycle.
- RUN, one action per cycle, evaluated in this priority:
  1. u==1: inv_out<=x1, done<=1, err<=0, go to IDLE.
  2. v==1: inv_out<=x2, done<=1, err<=0, go to IDLE.
  3. u even: u<=u>>1; x1<=half(x1).
  4. v even: v<=v>>1; x2<=half(x2).
  5. u>=v: u<=u-v; x1<=msub(x1,x2).
  6. else: v<=v-u; x2<=msub(x2,x1).

Arithmetic:
- half(x) is x>>1 if x is even, else (x+M)>>1, using a data_width+1-bit intermediate.
- msub(p,q) is p-q, plus M if p<q.
- x1 and x2 stay in [0,M-1], so inv_out is always canonical in [1,M-1].

Timing:
- In the done cycle, busy=0 and state=IDLE.
- start is ignored while busy=1: no queueing, a_in is not re-sampled.
- start asserted in the done cycle is accepted, giving back-to-back operation.
- RUN length is bounded by 2*(2*data_width) cycles, i.e. ≤1024 for 256 bits.
- Total latency is ≤1026 cycles from the start edge to done. The design needs no timeout.
- a_in==1 terminates on the first RUN cycle: done 2 cycles after start.

Width rules:
- Comparisons are unsigned.
- u and v never go negative, because subtraction only occurs in steps 5 and 6 under their guards.

Test Plan:
- a_in=1 -> done 2 cycles after start, inv_out=1, err=0, busy high exactly 1 cycle.
- a_in=2 -> inv_out=256'h39f6d3a994cebea4199cec0404d0ec02a9ded2017fff2dff7fffffff80000001, and a check that done arrives within 1026 cycles.
- a_in=M-1 -> inv_out=M-1. a_in=0 -> done next cycle, err=1, inv_out=0. a_in=M and a_in=2^256-1 -> err=1.
- 1000 random a_in in [1,M-1] -> reference model confirms (a_in*inv_out) mod M == 1, err=0. Also feed a_in and inv_out through modular_mul and expect 1 after its 3-cycle latency.
- Start pulsed every cycle while busy with changing a_in -> only the first operand is inverted. Start held high in the done cycle -> the new operation is accepted with no idle gap.
- rst asserted mid-RUN for 1 cycle -> next cycle busy=0, done=0, inv_out=0. A following start with a_in=3 returns inv_out=(2M+1)/3 correctly.

Source files
------------

// File: rtl/modular_inv.sv
// Sequential modular inverter: inv_out = a_in^-1 mod M by binary extended Euclid.
// One reduction step per clock. Operands and results are standard-domain residues.
// Invariants held while running: x1 * a == u (mod M) and x2 * a == v (mod M),
// with x1, x2 kept canonical in [0, M-1].
module modular_inv #(
    parameter int unsigned           data_width = 256,
    parameter logic [data_width-1:0] M          =
        256'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000001
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [data_width-1:0] a_in,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [data_width-1:0] inv_out
);

    localparam logic [data_width-1:0] One  = {{(data_width - 1){1'b0}}, 1'b1};
    localparam logic [data_width-1:0] Zero = '0;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e                state_q, state_d;
    logic [data_width-1:0] u_q, u_d;
    logic [data_width-1:0] v_q, v_d;
    logic [data_width-1:0] x1_q, x1_d;
    logic [data_width-1:0] x2_q, x2_d;
    logic [data_width-1:0] inv_q, inv_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    // x / 2 mod M: odd values get M added first (M is odd), so the sum is even.
    // The extra top bit holds the carry of x + M.
    function automatic logic [data_width-1:0] half(input logic [data_width-1:0] x);
        logic [data_width:0] s;
        s = {1'b0, x};
        if (x[0]) begin
            s = s + {1'b0, M};
        end
        return data_width'(s >> 1);
    endfunction

    // (p - q) mod M for p, q in [0, M-1]; the wrapped difference plus M lands back in range.
    function automatic logic [data_width-1:0] msub(input logic [data_width-1:0] p,
                                                    input logic [data_width-1:0] q);
        logic [data_width-1:0] d;
        d = p - q;
        if (p < q) begin
            d = d + M;
        end
        return d;
    endfunction

    logic a_invalid;
    assign a_invalid = (a_in == Zero) || (a_in >= M);

    // Next-state: accept in idle, otherwise one Euclid step in fixed priority order.
    always_comb begin
        state_d = state_q;
        u_d     = u_q;
        v_d     = v_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        inv_d   = inv_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (a_invalid) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                        inv_d  = Zero;
                    end else begin
                        u_d     = a_in;
                        v_d     = M;
                        x1_d    = One;
                        x2_d    = Zero;
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (u_q == One) begin
                    inv_d   = x1_q;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else if (v_q == One) begin
                    inv_d   = x2_q;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else if (!u_q[0]) begin
                    u_d  = u_q >> 1;
                    x1_d = half(x1_q);
                end else if (!v_q[0]) begin
                    v_d  = v_q >> 1;
                    x2_d = half(x2_q);
                end else if (u_q >= v_q) begin
                    u_d  = u_q - v_q;
                    x1_d = msub(x1_q, x2_q);
                end else begin
                    v_d  = v_q - u_q;
                    x2_d = msub(x2_q, x1_q);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; synchronous reset clears everything and aborts a run silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            u_q     <= Zero;
            v_q     <= Zero;
            x1_q    <= Zero;
            x2_q    <= Zero;
            inv_q   <= Zero;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            u_q     <= u_d;
            v_q     <= v_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            inv_q   <= inv_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign busy    = (state_q == StRun);
    assign done    = done_q;
    assign err     = err_q;
    assign inv_out = inv_q;

endmodule
